// File: rtl/async_transmitter.sv
// 8N1 UART transmitter. Each 16-bit word goes out as two frames, low byte first and LSB first.
// A one-word holding register lets words follow each other with no idle time on the line.
module async_transmitter #(
    parameter int ClkFrequency = 25000000,
    parameter int Baud         = 115200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        TxD_start,
    input  logic [15:0] TxD_data,
    output logic        TxD_ready,
    output logic        TxD_busy,
    output logic        TxD_done,
    output logic        TxD
);

    localparam int BitCycles = ClkFrequency / Baud;
    localparam int CntW      = (BitCycles < 2) ? 1 : $clog2(BitCycles);

    generate
        if (BitCycles < 2) begin : gBadBitCycles
            $error("async_transmitter: ClkFrequency/Baud must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } TxState;

    TxState          state;
    logic [15:0]     holdData;
    logic            holdValid;
    logic [15:0]     shiftWord;
    logic            byteIdx;
    logic [2:0]      bitIdx;
    logic [CntW-1:0] bitCnt;
    logic            txdReg;
    logic            busyReg;
    logic            doneReg;

    logic            bitEnd;
    logic [7:0]      curByte;
    logic [2:0]      nextBit;
    logic            accept;
    logic            loadNow;

    // The holding register is empty exactly when a load cannot be pending,
    // so accepting and loading never happen on the same edge.
    always_comb begin
        bitEnd  = (bitCnt == CntW'(BitCycles - 1));
        curByte = byteIdx ? shiftWord[15:8] : shiftWord[7:0];
        nextBit = bitIdx + 3'd1;
        accept  = TxD_start & ~holdValid;
        loadNow = holdValid &
                  ((state == IDLE) | ((state == STOP) & bitEnd & byteIdx));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            holdData  <= '0;
            holdValid <= 1'b0;
            shiftWord <= '0;
            byteIdx   <= 1'b0;
            bitIdx    <= '0;
            bitCnt    <= '0;
            txdReg    <= 1'b1;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
        end else begin
            doneReg <= 1'b0;

            if (accept) begin
                holdData  <= TxD_data;
                holdValid <= 1'b1;
            end else if (loadNow) begin
                holdValid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    txdReg  <= 1'b1;
                    busyReg <= 1'b0;
                    bitCnt  <= '0;
                    if (holdValid) begin
                        shiftWord <= holdData;
                        byteIdx   <= 1'b0;
                        state     <= START;
                        txdReg    <= 1'b0;
                        busyReg   <= 1'b1;
                    end
                end

                START: begin
                    if (bitEnd) begin
                        bitCnt <= '0;
                        bitIdx <= '0;
                        state  <= DATA;
                        txdReg <= curByte[0];
                    end else begin
                        bitCnt <= bitCnt + CntW'(1);
                    end
                end

                DATA: begin
                    if (bitEnd) begin
                        bitCnt <= '0;
                        if (bitIdx == 3'd7) begin
                            state  <= STOP;
                            txdReg <= 1'b1;
                        end else begin
                            bitIdx <= nextBit;
                            txdReg <= curByte[nextBit];
                        end
                    end else begin
                        bitCnt <= bitCnt + CntW'(1);
                    end
                end

                STOP: begin
                    if (bitEnd) begin
                        bitCnt <= '0;
                        if (!byteIdx) begin
                            byteIdx <= 1'b1;
                            state   <= START;
                            txdReg  <= 1'b0;
                        end else begin
                            doneReg <= 1'b1;
                            // A pending word starts straight after this stop bit.
                            if (holdValid) begin
                                shiftWord <= holdData;
                                byteIdx   <= 1'b0;
                                state     <= START;
                                txdReg    <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                busyReg <= 1'b0;
                            end
                        end
                    end else begin
                        bitCnt <= bitCnt + CntW'(1);
                    end
                end

                default: begin
                    state  <= IDLE;
                    txdReg <= 1'b1;
                end
            endcase
        end
    end

    assign TxD_ready = ~holdValid;
    assign TxD_busy  = busyReg;
    assign TxD_done  = doneReg;
    assign TxD       = txdReg;

endmodule
